golay_row_search: RTL and testbench

Parametrised, valid-qualified successor to the Golay(24,12) "syndrome plus parity row" search stage in the PROM ECC decoder.
- Each cycle it accepts a 12-bit vector V, which is either the syndrome S or B-transpose·S.
- It XORs V against all twelve rows of the parity matrix B and tests each result for weight ≤ WMAX.
- It emits the 24-bit error pattern for the highest-priority matching row, plus match/miss statistics.
- One instance serves both decode halves through a per-sample MODE bit, and sits between the syndrome generator and the error-correction XOR.

---
 rtl/golay_pkg.sv | 26 ++
 rtl/golay_wt_le.sv | 19 +
 rtl/golay_row_search.sv | 126 ++++++++++++
 tb/tb_golay_row_search.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/golay_pkg.sv
// golay_pkg: shared constants for the Golay(24,12) row-search stage.
//   K, N      - message / codeword widths
//   B_ROW     - the twelve parity-matrix rows, index 0 = row 1
//   E_NONE    - error pattern reported when no row qualifies
//   idr()     - identity row for a 0-based row index
package golay_pkg;

    localparam int N = 24;
    localparam int K = 12;
    localparam int NROWS = 12;

    localparam logic [N-1:0] E_NONE = 24'hFFFFFF;

    localparam logic [K-1:0] B_ROW [NROWS] = '{
        12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B, 12'hF16, 12'hE2D,
        12'hC5B, 12'h8B7, 12'h96E, 12'hADC, 12'hDB8, 12'hB71
    };

    // Identity row: MSB-first one-hot, row 1 -> 12'h800.
    function automatic logic [K-1:0] idr(input int idx);
        logic [K-1:0] top;
        top = 12'h800;
        return top >> idx;
    endfunction

endpackage

// File: rtl/golay_wt_le.sv
// golay_wt_le: registered weight-threshold test, one cycle of latency.
//   CLK, RST - clock, synchronous active-high reset
//   V        - 12-bit vector under test
//   LE       - registered (popcount(V) <= WMAX)
module golay_wt_le #(
    parameter int WMAX = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] V,
    output logic        LE
);

    always_ff @(posedge CLK) begin
        if (RST) LE <= 1'b0;
        else     LE <= ($countones(V) <= WMAX);
    end

endmodule

// File: rtl/golay_row_search.sv
// golay_row_search: XORs a 12-bit vector against all twelve B rows, flags
// rows within WMAX of it, and reports the lowest-index match as a 24-bit
// error pattern. Three-stage free-running pipeline, one sample per cycle.
//   CLK, RST          - clock, synchronous active-high reset
//   IN_VLD, V, MODE   - sample in (MODE=1 puts the identity row in the top half)
//   TAG               - sideband carried with the sample
//   CLR_CNT           - zero both statistics counters
//   OUT_VLD, E, USE,
//   ROW, TAG_OUT      - stage-3 result, updated every cycle
//   HIT_CNT, MISS_CNT - saturating counts of valid matched / unmatched samples
module golay_row_search
    import golay_pkg::*;
#(
    parameter int WMAX  = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VLD,
    input  logic [11:0]      V,
    input  logic             MODE,
    input  logic [TAG_W-1:0] TAG,
    input  logic             CLR_CNT,
    output logic             OUT_VLD,
    output logic [23:0]      E,
    output logic             USE,
    output logic [3:0]       ROW,
    output logic [TAG_W-1:0] TAG_OUT,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] MISS_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // vld_pipe[s] is the valid bit held in stage s
    logic [3:1]            vld_pipe;
    logic [2:1]            mode_pipe;
    logic [TAG_W-1:0]      tag1, tag2;
    logic [NROWS-1:0][K-1:0] x1, x2;
    logic [NROWS-1:0]      m2;

    assign OUT_VLD = vld_pipe[3];

    // Stage 1: row XORs; stage 2: delay line alongside the weight tests
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe[2:1] <= '0;
            mode_pipe     <= '0;
            tag1          <= '0;
            tag2          <= '0;
            x1            <= '0;
            x2            <= '0;
        end else begin
            vld_pipe[2:1] <= {vld_pipe[1], IN_VLD};
            mode_pipe     <= {mode_pipe[1], MODE};
            tag1          <= TAG;
            tag2          <= tag1;
            for (int i = 0; i < NROWS; i++) x1[i] <= V ^ B_ROW[i];
            x2            <= x1;
        end
    end

    for (genvar g = 0; g < NROWS; g++) begin : g_wt
        golay_wt_le #(.WMAX(WMAX)) u_wt (
            .CLK (CLK),
            .RST (RST),
            .V   (x1[g]),
            .LE  (m2[g])
        );
    end

    // Stage 3 priority select: walking down from row 12 leaves the lowest
    // matching index in k.
    logic        hit;
    int          k;
    logic [23:0] e_nxt;
    logic [3:0]  row_nxt;

    always_comb begin
        hit     = 1'b0;
        k       = 0;
        e_nxt   = E_NONE;
        row_nxt = 4'd0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (m2[i]) begin
                hit = 1'b1;
                k   = i;
            end
        end
        if (hit) begin
            e_nxt   = mode_pipe[2] ? {idr(k), x2[k]} : {x2[k], idr(k)};
            row_nxt = 4'(k + 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe[3] <= 1'b0;
            E           <= E_NONE;
            USE         <= 1'b0;
            ROW         <= 4'd0;
            TAG_OUT     <= '0;
            HIT_CNT     <= '0;
            MISS_CNT    <= '0;
        end else begin
            vld_pipe[3] <= vld_pipe[2];
            E           <= e_nxt;
            USE         <= hit;
            ROW         <= row_nxt;
            TAG_OUT     <= tag2;
            // A clear swallows the sample completing on the same edge.
            if (CLR_CNT) begin
                HIT_CNT  <= '0;
                MISS_CNT <= '0;
            end else if (vld_pipe[2]) begin
                if (hit) begin
                    if (HIT_CNT != '1) HIT_CNT <= HIT_CNT + CNT_ONE;
                end else begin
                    if (MISS_CNT != '1) MISS_CNT <= MISS_CNT + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_golay_row_search.sv
module tb_golay_row_search;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VLD = 1'b0;
    logic [11:0] V = '0;
    logic        MODE = 1'b0;
    logic [3:0]  TAG = '0;
    logic        CLR_CNT = 1'b0;

    logic        OUT_VLD, USE;
    logic [23:0] E;
    logic [3:0]  ROW, TAG_OUT;
    logic [15:0] HIT_CNT, MISS_CNT;

    logic        s_OUT_VLD, s_USE;
    logic [23:0] s_E;
    logic [3:0]  s_ROW, s_TAG_OUT;
    logic [3:0]  s_HIT_CNT, s_MISS_CNT;

    golay_row_search #(.WMAX(2), .TAG_W(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .V(V), .MODE(MODE), .TAG(TAG),
        .CLR_CNT(CLR_CNT), .OUT_VLD(OUT_VLD), .E(E), .USE(USE), .ROW(ROW),
        .TAG_OUT(TAG_OUT), .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
    );

    // Narrow-counter instance for saturation
    golay_row_search #(.WMAX(2), .TAG_W(4), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .V(V), .MODE(MODE), .TAG(TAG),
        .CLR_CNT(CLR_CNT), .OUT_VLD(s_OUT_VLD), .E(s_E), .USE(s_USE), .ROW(s_ROW),
        .TAG_OUT(s_TAG_OUT), .HIT_CNT(s_HIT_CNT), .MISS_CNT(s_MISS_CNT)
    );

    always #5 CLK = ~CLK;

    logic [11:0] brow [12] = '{12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B, 12'hF16, 12'hE2D,
                               12'hC5B, 12'h8B7, 12'h96E, 12'hADC, 12'hDB8, 12'hB71};

    typedef struct {
        logic [23:0] e;
        logic        hit;
        logic [3:0]  row;
        logic [3:0]  tag;
        int          due;
    } sb_t;

    typedef struct {
        logic [11:0] v;
        logic        mode;
        logic [3:0]  tag;
        logic        vld;
        logic [23:0] e;
        logic        hit;
        logic [3:0]  row;
    } vec_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  rst_q = 1'b1, clr_q = 1'b0;
    int  exp_hit = 0, exp_miss = 0, exp_hit4 = 0, exp_miss4 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic sb_t model(input logic [11:0] v, input logic mode, input logic [3:0] tag);
        sb_t r;
        logic [11:0] x, id, top;
        bit found;
        top = 12'h800;
        found = 0;
        r.e = 24'hFFFFFF; r.hit = 0; r.row = 0; r.tag = tag; r.due = 0;
        for (int i = 0; i < 12; i++) begin
            x = v ^ brow[i];
            if (!found && $countones(x) <= 2) begin
                found = 1;
                id = top >> i;
                r.e = mode ? {id, x} : {x, id};
                r.hit = 1;
                r.row = 4'(i + 1);
            end
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        rst_q = RST;
        clr_q = CLR_CNT;
    end

    // Scoreboard / counter model
    always @(negedge CLK) begin
        sb_t s;
        if (rst_q) begin
            exp_hit = 0; exp_miss = 0; exp_hit4 = 0; exp_miss4 = 0;
        end else begin
            if (OUT_VLD) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out_vld", 32'(OUT_VLD), 32'd0);
                end else begin
                    s = sbq.pop_front();
                    chk("latency_cycle", cyc, s.due);
                    chk("E", 32'(E), 32'(s.e));
                    chk("USE", 32'(USE), 32'(s.hit));
                    chk("ROW", 32'(ROW), 32'(s.row));
                    chk("TAG_OUT", 32'(TAG_OUT), 32'(s.tag));
                    if (!clr_q) begin
                        if (s.hit) begin
                            if (exp_hit < 65535) exp_hit++;
                            if (exp_hit4 < 15) exp_hit4++;
                        end else begin
                            if (exp_miss < 65535) exp_miss++;
                            if (exp_miss4 < 15) exp_miss4++;
                        end
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                chk("missing_out_vld", 32'(OUT_VLD), 32'd1);
                void'(sbq.pop_front());
            end
            if (clr_q) begin
                exp_hit = 0; exp_miss = 0; exp_hit4 = 0; exp_miss4 = 0;
            end
            chk("HIT_CNT", 32'(HIT_CNT), exp_hit);
            chk("MISS_CNT", 32'(MISS_CNT), exp_miss);
            chk("HIT_CNT_w4", 32'(s_HIT_CNT), exp_hit4);
            chk("MISS_CNT_w4", 32'(s_MISS_CNT), exp_miss4);
        end
    end

    task automatic drive_exp(input logic vld, input logic [11:0] v, input logic mode,
                             input logic [3:0] tag, input logic clr, input sb_t exp);
        sb_t s;
        @(posedge CLK); #1;
        IN_VLD = vld; V = v; MODE = mode; TAG = tag; CLR_CNT = clr;
        if (vld) begin
            s = exp;
            s.due = cyc + 3;
            sbq.push_back(s);
        end
    endtask

    task automatic drive(input logic vld, input logic [11:0] v, input logic mode,
                         input logic [3:0] tag, input logic clr);
        drive_exp(vld, v, mode, tag, clr, model(v, mode, tag));
    endtask

    task automatic drain();
        repeat (6) drive(0, 12'h0, 0, 4'h0, 0);
        chk("sb_drained", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1; IN_VLD = 0; CLR_CNT = 0;
        @(posedge CLK);
        sbq.delete();
        @(posedge CLK); #1;
        RST = 0;
    endtask

    vec_t tbl [12];

    initial begin
        sb_t ex;
        logic [11:0] mask;

        tbl[0]  = '{12'h7FF, 1, 4'h5, 1, 24'h800000, 1, 4'd1};
        tbl[1]  = '{12'hEE3, 1, 4'h1, 1, 24'h400001, 1, 4'd2};
        tbl[2]  = '{12'hEE3, 0, 4'h2, 1, 24'h001400, 1, 4'd2};
        tbl[3]  = '{12'h000, 0, 4'h3, 1, 24'hFFFFFF, 0, 4'd0};
        tbl[4]  = '{12'h7FE, 0, 4'h4, 1, 24'h001800, 1, 4'd1};
        tbl[5]  = '{12'h123, 1, 4'hC, 0, 24'h0,      0, 4'd0};
        tbl[6]  = '{12'hDC5, 1, 4'h6, 1, 24'h200000, 1, 4'd3};
        tbl[7]  = '{12'hC5B, 0, 4'h7, 1, 24'h000020, 1, 4'd7};
        tbl[8]  = '{12'hB71, 1, 4'h8, 1, 24'h001000, 1, 4'd12};
        tbl[9]  = '{12'hB71, 0, 4'h9, 1, 24'h000001, 1, 4'd12};
        tbl[10] = '{12'hB74, 1, 4'hA, 1, 24'h001005, 1, 4'd12};
        tbl[11] = '{12'hB76, 0, 4'hB, 1, 24'hFFFFFF, 0, 4'd0};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_OUT_VLD", 32'(OUT_VLD), 0);
        chk("rst_E", 32'(E), 32'hFFFFFF);
        chk("rst_USE", 32'(USE), 0);
        chk("rst_ROW", 32'(ROW), 0);
        chk("rst_TAG_OUT", 32'(TAG_OUT), 0);
        chk("rst_HIT_CNT", 32'(HIT_CNT), 0);
        chk("rst_MISS_CNT", 32'(MISS_CNT), 0);
        @(posedge CLK); #1;
        RST = 0;

        // Table vectors, back-to-back
        foreach (tbl[i]) begin
            ex = '{tbl[i].e, tbl[i].hit, tbl[i].row, tbl[i].tag, 0};
            drive_exp(tbl[i].vld, tbl[i].v, tbl[i].mode, tbl[i].tag, 0, ex);
        end
        drain();

        // Stream 7FF, idle, 000, 7FF after a counter clear
        drive(0, 12'h0, 0, 4'h0, 1);
        drive(1, 12'h7FF, 1, 4'h1, 0);
        drive(0, 12'h0, 0, 4'h0, 0);
        drive(1, 12'h000, 0, 4'h2, 0);
        drive(1, 12'h7FF, 0, 4'h3, 0);
        drain();
        chk("stream_HIT_CNT", 32'(HIT_CNT), 2);
        chk("stream_MISS_CNT", 32'(MISS_CNT), 1);

        // Clear on the same edge as a valid hit completing
        drive(1, 12'h7FF, 1, 4'h4, 0);
        drive(0, 12'h0, 0, 4'h0, 0);
        drive(0, 12'h0, 0, 4'h0, 1);
        drive(0, 12'h0, 0, 4'h0, 0);
        @(negedge CLK);
        chk("clr_edge_OUT_VLD", 32'(OUT_VLD), 1);
        chk("clr_edge_HIT_CNT", 32'(HIT_CNT), 0);
        drain();

        // Reset with two samples in flight
        drive(1, 12'h7FF, 1, 4'h5, 0);
        drive(1, 12'h000, 0, 4'h6, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("post_rst_OUT_VLD", 32'(OUT_VLD), 0);
        end
        chk("post_rst_HIT_CNT", 32'(HIT_CNT), 0);
        chk("post_rst_MISS_CNT", 32'(MISS_CNT), 0);

        // Saturation of the 4-bit counters
        for (int i = 0; i < 18; i++) drive(1, 12'h7FF, i[0], 4'(i), 0);
        drain();
        chk("sat_HIT_w4", 32'(s_HIT_CNT), 32'hF);
        chk("sat_HIT_w16", 32'(HIT_CNT), 18);

        // Reset and clear together
        @(posedge CLK); #1;
        RST = 1; CLR_CNT = 1;
        @(posedge CLK); #1;
        RST = 0; CLR_CNT = 0;
        @(negedge CLK);
        chk("rst_clr_HIT_CNT", 32'(HIT_CNT), 0);
        chk("rst_clr_OUT_VLD", 32'(OUT_VLD), 0);

        // Random stream: near-row vectors and arbitrary vectors
        for (int i = 0; i < 60; i++) begin
            mask = '0;
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                mask[$urandom_range(0, 11)] = 1'b1;
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? (brow[$urandom_range(0, 11)] ^ mask)
                                               : 12'($urandom),
                  1'($urandom), 4'($urandom), 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
